if_prefetch_buffer: RTL

- Instruction prefetch stage between the instruction memory and the decode/control unit.
- Issues sequential word fetches to a variable-latency instruction memory and queues the returned {pc, instruction} pairs in a small FIFO.
- Presents the FIFO head to decode through a valid/ready handshake.
- Execute redirects it on taken branches and jumps: the FIFO is flushed and any in-flight fetch is discarded.

---
 rtl/if_prefetch_buffer.sv | 89 ++++++++
 1 files changed

// File: rtl/if_prefetch_buffer.sv
// if_prefetch_buffer: sequential instruction prefetch into a small {pc, instr} FIFO with redirect flush
module if_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_fetch_pc;
    logic [AW:0] r_count;
    logic [AW:0] w_count_nxt;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [31:0] r_pc_mem    [DEPTH];
    logic [31:0] r_instr_mem [DEPTH];
    logic        w_push;
    logic        w_pop;
    logic        w_issue;

    assign out_valid = r_count != '0;
    assign out_pc    = out_valid ? r_pc_mem[r_rd_ptr] : '0;
    assign out_instr = out_valid ? r_instr_mem[r_rd_ptr] : '0;

    // Next occupancy and fetch state before deciding whether a new request can go out this edge
    always_comb begin
        w_push      = (r_state == WAIT) && imem_rvalid && !redirect;
        w_pop       = out_valid && out_ready && !redirect;
        w_count_nxt = redirect ? '0 : r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        w_state_nxt = redirect ? ((r_state != IDLE && !imem_rvalid) ? DROP : IDLE)
                    : (r_state != IDLE && imem_rvalid) ? IDLE : r_state;
        w_issue     = !redirect && (w_state_nxt == IDLE) && (w_count_nxt < (AW+1)'(DEPTH));
    end

    // Fetch FSM; imem_addr doubles as the pc of the outstanding request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
        end else begin
            imem_req <= w_issue;
            r_state  <= w_issue ? WAIT : w_state_nxt;
            if (redirect)
                r_fetch_pc <= redirect_pc & ~32'h3;
            else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                imem_addr  <= r_fetch_pc;
            end
        end
    end

    // FIFO occupancy and pointers; a redirect empties the queue and cancels any pop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count  <= w_count_nxt;
            r_wr_ptr <= redirect ? '0 : r_wr_ptr + AW'(w_push);
            r_rd_ptr <= redirect ? '0 : r_rd_ptr + AW'(w_pop);
        end
    end

    // FIFO storage, written with the pc of the request that produced the word
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= imem_addr;
            r_instr_mem[r_wr_ptr] <= imem_rdata;
        end
    end
endmodule
